// File: rtl/llr_format_converter.sv
// Two-stage elastic LLR format converter (two's complement <-> sign-magnitude).
// Flags the unrepresentable corner codes and counts them in a saturating counter.
module llr_format_converter #(
    parameter int W     = 9,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_sat,
    input  logic               sat_clr,
    output logic [CNT_W-1:0]   sat_count
);

    localparam int PW = $clog2(LANES + 1);
    localparam int SW = CNT_W + PW;

    logic               s1_valid;
    logic [LANES*W-1:0] s1_data;
    logic [LANES-1:0]   s1_sat;
    logic               s2_adv;
    logic               in_fire;
    logic [LANES*W-1:0] conv_data;
    logic [LANES-1:0]   conv_sat;
    logic [PW-1:0]      pop;
    logic [SW-1:0]      sat_sum;

    // Returns {flag, converted lane}; mode 0 = T2S, mode 1 = S2T.
    function automatic logic [W:0] conv_lane(input logic mode, input logic [W-1:0] x);
        logic [W-2:0] mag;
        logic [W-1:0] y;
        logic         f;
        mag = x[W-2:0];
        y   = x;
        f   = 1'b0;
        if (x[W-1]) begin
            if (mag == '0) begin
                f = 1'b1;
                y = mode ? '0 : '1;
            end else if (mode) begin
                y = ~{1'b0, mag} + W'(1);
            end else begin
                y = {1'b1, (~mag) + (W-1)'(1)};
            end
        end
        return {f, y};
    endfunction

    assign s2_adv   = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_adv;
    assign in_fire  = in_valid & in_ready;

    // Per-lane conversion of the incoming beat and popcount of its flags.
    always_comb begin
        conv_data = '0;
        conv_sat  = '0;
        pop       = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [W:0] r;
            r = conv_lane(in_mode, in_data[i*W +: W]);
            conv_data[i*W +: W] = r[W-1:0];
            conv_sat[i]         = r[W];
            pop                 = pop + PW'(r[W]);
        end
    end

    assign sat_sum = {{PW{1'b0}}, sat_count} + SW'(pop);

    // Stage 1: capture converted lanes whenever the stage is free or moving on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_sat   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= conv_data;
                s1_sat  <= conv_sat;
            end
        end
    end

    // Stage 2: output register, held stable while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_data;
                out_sat  <= s1_sat;
            end
        end
    end

    // Saturating count of flagged lanes on accepted beats; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (in_fire) begin
            if (sat_sum > SW'({CNT_W{1'b1}}))
                sat_count <= '1;
            else
                sat_count <= sat_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_llr_format_converter.sv
// Self-checking bench for llr_format_converter: vector table, backpressure,
// random streaming against an arithmetic model, counter and reset cases.
module tb_llr_format_converter;

    localparam int W  = 9;
    localparam int L  = 4;
    localparam int DW = W * L;
    localparam int HALF = 1 << (W - 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [L-1:0]  out_sat;
    logic          sat_clr;
    logic [15:0]   sat_count;

    logic          c4_in_ready;
    logic          c4_out_valid;
    logic [DW-1:0] c4_out_data;
    logic [L-1:0]  c4_out_sat;
    logic [3:0]    c4_sat_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    llr_format_converter #(.W(W), .LANES(L), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_count(sat_count)
    );

    llr_format_converter #(.W(W), .LANES(L), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_mode(in_mode), .in_data(in_data),
        .out_valid(c4_out_valid), .out_ready(out_ready),
        .out_data(c4_out_data), .out_sat(c4_out_sat),
        .sat_clr(sat_clr), .sat_count(c4_sat_count)
    );

    typedef struct {
        logic          mode;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        logic [L-1:0]  s;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pk(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    // Arithmetic reference: works on lane values as integers.
    function automatic void model(input logic mode, input logic [DW-1:0] d,
                                  output logic [DW-1:0] o, output logic [L-1:0] s);
        o = '0;
        s = '0;
        for (int i = 0; i < L; i++) begin
            int x, y, m;
            x = int'(d[i*W +: W]);
            y = x;
            if (x >= HALF) begin
                if (!mode) begin
                    if (x == HALF) begin
                        y = 2 * HALF - 1;
                        s[i] = 1'b1;
                    end else begin
                        y = HALF + (2 * HALF - x);
                    end
                end else begin
                    m = x - HALF;
                    if (m == 0) begin
                        y = 0;
                        s[i] = 1'b1;
                    end else begin
                        y = 2 * HALF - m;
                    end
                end
            end
            o[i*W +: W] = W'(y);
        end
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < L; i++) begin
            if ($urandom_range(0, 5) == 0)
                r[i*W +: W] = W'(HALF);
            else
                r[i*W +: W] = W'($urandom_range(0, 2 * HALF - 1));
        end
        return r;
    endfunction

    initial begin
        logic [DW-1:0] q_d[$];
        logic [L-1:0]  q_s[$];
        logic [DW-1:0] ed;
        logic [L-1:0]  es;
        int sent, got, cyc, exp_cnt;

        vt[0] = '{1'b0, pk('h1F6, 'h00A, 'h000, 'h0FF), pk('h10A, 'h00A, 'h000, 'h0FF), 4'b0000};
        vt[1] = '{1'b0, pk('h100, 'h000, 'h000, 'h000), pk('h1FF, 'h000, 'h000, 'h000), 4'b0001};
        vt[2] = '{1'b1, pk('h100, 'h10A, 'h0FF, 'h001), pk('h000, 'h1F6, 'h0FF, 'h001), 4'b0001};
        vt[3] = '{1'b0, pk('h1FF, 'h101, 'h100, 'h080), pk('h101, 'h1FF, 'h1FF, 'h080), 4'b0100};
        vt[4] = '{1'b1, pk('h1FF, 'h101, 'h000, 'h100), pk('h101, 'h1FF, 'h000, 'h000), 4'b1000};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        sat_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_sat", 64'(out_sat), 64'(0));
        chk("rst_sat_count", 64'(sat_count), 64'(0));
        #3 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Table: one beat at a time, 2-cycle latency
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_mode = vt[i].mode;
            in_data = vt[i].d;
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(1));
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_lat1", i), 64'(out_valid), 64'(0));
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'(vt[i].e));
            chk($sformatf("tbl%0d_sat", i), 64'(out_sat), 64'(vt[i].s));
        end
        chk("tbl_sat_count", 64'(sat_count), 64'(4));
        chk("tbl_c4_count", 64'(c4_sat_count), 64'(4));
        tick();

        // Backpressure: A, B accepted, C stalls until release
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_data = pk('h1F6, 'h00A, 'h000, 'h0FF);
        chk("bp_ready_a", 64'(in_ready), 64'(1));
        tick();
        in_mode = 1'b1;
        in_data = pk('h10A, 'h0FF, 'h1FF, 'h001);
        chk("bp_ready_b", 64'(in_ready), 64'(1));
        tick();
        in_mode = 1'b0;
        in_data = pk('h001, 'h1FF, 'h17F, 'h000);
        chk("bp_full", 64'(in_ready), 64'(0));
        chk("bp_a_out", 64'(out_data), 64'(pk('h10A, 'h00A, 'h000, 'h0FF)));
        tick();
        chk("bp_still_full", 64'(in_ready), 64'(0));
        chk("bp_hold", 64'({out_valid, out_data}), 64'({1'b1, pk('h10A, 'h00A, 'h000, 'h0FF)}));
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_b_out", 64'({out_valid, out_data}), 64'({1'b1, pk('h1F6, 'h0FF, 'h101, 'h001)}));
        tick();
        chk("bp_c_out", 64'({out_valid, out_data}), 64'({1'b1, pk('h001, 'h101, 'h181, 'h000)}));
        tick();
        chk("bp_drained", 64'(out_valid), 64'(0));

        // Random streaming against the model
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        sent = 0;
        got = 0;
        cyc = 0;
        exp_cnt = 0;
        while ((got < 100) && (cyc < 3000)) begin
            if ((sent < 100) && ($urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                in_mode = 1'($urandom_range(0, 1));
                in_data = rand_beat();
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                model(in_mode, in_data, ed, es);
                q_d.push_back(ed);
                q_s.push_back(es);
                exp_cnt += $countones(es);
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q_d.size() == 0) begin
                    chk("stream_extra_beat", 64'(1), 64'(0));
                end else begin
                    ed = q_d.pop_front();
                    es = q_s.pop_front();
                    chk($sformatf("stream%0d", got), 64'({out_sat, out_data}), 64'({es, ed}));
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("stream_timeout", 64'(cyc < 3000), 64'(1));
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("stream_sat_count", 64'(sat_count), 64'(exp_cnt));

        // Counter saturation: 20 flagged lanes
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("clr_main", 64'(sat_count), 64'(0));
        chk("clr_c4", 64'(c4_sat_count), 64'(0));
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_data = pk('h100, 'h100, 'h100, 'h100);
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        chk("cnt_main_20", 64'(sat_count), 64'(20));
        chk("cnt_c4_sat15", 64'(c4_sat_count), 64'(15));
        tick();
        tick();

        // Clear wins over a same-cycle saturating handshake
        in_valid = 1'b1;
        in_mode = 1'b1;
        in_data = pk('h100, 'h000, 'h000, 'h000);
        sat_clr = 1'b1;
        chk("clr_hs_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        sat_clr = 1'b0;
        chk("clr_hs_main", 64'(sat_count), 64'(0));
        chk("clr_hs_c4", 64'(c4_sat_count), 64'(0));
        tick();
        tick();

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_data = pk('h100, 'h001, 'h002, 'h003);
        tick();
        in_mode = 1'b1;
        in_data = pk('h000, 'h100, 'h002, 'h003);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_count", 64'(sat_count), 64'(2));
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_count", 64'(sat_count), 64'(0));
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_no_ghost", 64'(out_valid), 64'(0));
        in_valid = 1'b1;
        in_mode = 1'b0;
        in_data = pk('h1F6, 'h000, 'h000, 'h000);
        tick();
        in_valid = 1'b0;
        chk("post_rst_lat1", 64'(out_valid), 64'(0));
        tick();
        chk("post_rst_beat", 64'({out_valid, out_data}), 64'({1'b1, pk('h10A, 'h000, 'h000, 'h000)}));
        tick();
        chk("post_rst_drain", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
